regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 8x8 register file (regwrite/wa/wd) between NREQ writeback sources.

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and arbitration helpers.
// The register file, decode and the writeback arbiter all import this package.
package regfile_wb_arbiter_pkg;

  localparam int RF_AW     = 3;
  localparam int RF_DW     = 8;
  localparam int RF_NREG   = 2 ** RF_AW;
  localparam int RF_MAXREQ = 4;

  // Index of a writeback requester. It is always 2 bits wide, whatever NREQ is.
  typedef logic [1:0] req_idx_t;

  // Convert a one-hot grant vector to its index. Returns 0 when the vector is all zero.
  function automatic req_idx_t onehot_to_idx(input logic [RF_MAXREQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < RF_MAXREQ; i++) begin
      if (oh[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and the register-file write port.
// master = writeback units plus the register file side; slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 8
);

  logic                 stall;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_regwrite;
  logic [AW-1:0]        rf_wa;
  logic [DW-1:0]        rf_wd;
  logic [1:0]           grant_id;
  logic [(2**AW)-1:0]   pend;

  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, rf_regwrite, rf_wa, rf_wd, grant_id, pend
  );

  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, rf_regwrite, rf_wa, rf_wd, grant_id, pend
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// It grants the first requester at or after ptr_i, searching cyclically.
// The pointer register belongs to the instantiating block.
module regfile_wb_arbiter_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  req_idx_t     ptr_i,
  output logic [N-1:0] gnt_o,
  output req_idx_t     gnt_idx_o,
  output logic         any_o
);

  localparam int SW = (N > 2) ? 2 : 1;

  logic [SW-1:0] slot;
  logic          found;

  // Cyclic priority search starting at the pointer; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
    gnt_o = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      slot = SW'((int'(ptr_i) + k) % N);
      if (!found && req_i[slot]) begin
        gnt_o[slot] = 1'b1;
        found       = 1'b1;
      end
    end
    any_o     = found;
    gnt_idx_o = onehot_to_idx(RF_MAXREQ'(gnt_o));
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter in front of the single register-file write port.
// The winning write goes into a one-entry output stage.
// pend flags the register that the output stage will commit at the next edge.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  localparam req_idx_t LAST_IDX = req_idx_t'(NREQ - 1);

  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] gnt;
  req_idx_t        gnt_idx;
  logic            any_gnt;

  req_idx_t        ptr_q, ptr_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  req_idx_t        gid_q, gid_d;

  // No grant is possible while in reset or while decode stalls.
  assign req_eff = (rst || bus.stall) ? '0 : bus.req_valid;

  regfile_wb_arbiter_rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .req_i     (req_eff),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_gnt)
  );

  assign bus.req_ready = gnt;

  // Next state: load the winner into the output stage and move the pointer past it.
  always_comb begin
    ptr_d = ptr_q;
    wr_d  = any_gnt;
    wa_d  = wa_q;
    wd_d  = wd_q;
    gid_d = gid_q;
    if (any_gnt) begin
      ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 2'd1;
      gid_d = gnt_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          wa_d = bus.req_addr[i*AW +: AW];
          wd_d = bus.req_data[i*DW +: DW];
        end
      end
    end
  end

  // Pointer and output-stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register update from pre-edge values, whatever the statement order.
    if (rst) begin
      ptr_q <= '0;
      wr_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      gid_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
      gid_q <= gid_d;
    end
  end

  // rst blanks a held write in the same cycle, so the register file never commits it.
  assign bus.rf_regwrite = wr_q & ~rst;
  assign bus.rf_wa       = wa_q;
  assign bus.rf_wd       = wd_q;
  assign bus.grant_id    = gid_q;

  // At most one pending bit: the destination of the write about to commit.
  always_comb begin
    bus.pend = '0;
    if (bus.rf_regwrite) bus.pend[wa_q] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// The arbiter drives a small register file built into the bench.
// A behavioural model predicts grants, the output stage and register contents every cycle.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file written from the arbiter outputs
  logic [DW-1:0] rf_mem [NREG] = '{default: '0};
  always @(posedge clk) if (bus.rf_regwrite) rf_mem[bus.rf_wa] <= bus.rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit              model_on = 1'b0;
  int              m_ptr = 0;
  bit              m_wr  = 1'b0;
  int              m_wa  = 0;
  int              m_wd  = 0;
  int              m_gid = 0;
  int              m_rf [NREG] = '{default: 0};
  int              mg;
  logic [NREQ-1:0] e_ready;
  bit              e_wr;
  logic [NREG-1:0] e_pend;

  // Each cycle: predict the outputs, compare them, then advance the model across the next edge.
  always @(negedge clk) begin
    if (model_on) begin
      mg = -1;
      if (!rst && !bus.stall) begin
        for (int k = 0; k < NREQ; k++) begin
          if (mg < 0 && bus.req_valid[(m_ptr + k) % NREQ]) mg = (m_ptr + k) % NREQ;
        end
      end
      e_ready = '0;
      if (mg >= 0) e_ready[mg] = 1'b1;
      e_wr   = m_wr && !rst;
      e_pend = '0;
      if (e_wr) e_pend[m_wa] = 1'b1;

      check("req_ready",   32'(bus.req_ready),   32'(e_ready));
      check("rf_regwrite", 32'(bus.rf_regwrite), 32'(e_wr));
      check("rf_wa",       32'(bus.rf_wa),       m_wa);
      check("rf_wd",       32'(bus.rf_wd),       m_wd);
      check("grant_id",    32'(bus.grant_id),    m_gid);
      check("pend",        32'(bus.pend),        32'(e_pend));
      for (int r = 0; r < NREG; r++) check($sformatf("rf[%0d]", r), 32'(rf_mem[r]), m_rf[r]);

      if (rst) begin
        m_ptr = 0; m_wr = 1'b0; m_wa = 0; m_wd = 0; m_gid = 0;
      end else begin
        if (m_wr) m_rf[m_wa] = m_wd;
        if (mg >= 0) begin
          m_wr  = 1'b1;
          m_wa  = int'(bus.req_addr[mg*AW +: AW]);
          m_wd  = int'(bus.req_data[mg*DW +: DW]);
          m_gid = mg;
          m_ptr = (mg + 1) % NREQ;
        end else begin
          m_wr = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  logic [NREQ-1:0] granted;

  initial begin
    bus.stall     = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    tick();
    model_on = 1'b1;

    // 1: reset held with both requesters valid
    bus.req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready",    32'(bus.req_ready),   32'h0);
      check("rst_regwrite", 32'(bus.rf_regwrite), 32'h0);
      check("rst_pend",     32'(bus.pend),        32'h0);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;

    // 2: single write addr 1 data 67
    bus.req_valid = 2'b01;
    bus.req_addr  = {3'd0, 3'd1};
    bus.req_data  = {8'd0, 8'd67};
    @(negedge clk);
    check("t2_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("t2_regwrite", 32'(bus.rf_regwrite), 32'h1);
    check("t2_wa",       32'(bus.rf_wa),       32'd1);
    check("t2_wd",       32'(bus.rf_wd),       32'd67);
    check("t2_pend",     32'(bus.pend),        32'h02);
    tick();
    @(negedge clk);
    check("t2_rd1",  32'(rf_mem[1]), 32'd67);
    check("t2_pend0", 32'(bus.pend), 32'h00);

    // 3: round-robin from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_addr  = {3'd3, 3'd2};
    bus.req_data  = {8'd20, 8'd10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t3_grant%0d", i), 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    check("t3_r2", 32'(rf_mem[2]), 32'd10);
    check("t3_r3", 32'(rf_mem[3]), 32'd20);

    // 4: same-address conflict from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_addr  = {3'd5, 3'd5};
    bus.req_data  = {8'h55, 8'hAA};
    @(negedge clk);
    check("t4_first", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("t4_second", 32'(bus.req_ready), 32'h2);
    check("t4_wd0",    32'(bus.rf_wd),     32'hAA);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("t4_wd1", 32'(bus.rf_wd), 32'h55);
    tick();
    @(negedge clk);
    check("t4_r5", 32'(rf_mem[5]), 32'h55);

    // 5: stall; the grant of requester 0 moves ptr to 1 first
    bus.req_valid = 2'b01;
    bus.req_addr  = {3'd7, 3'd6};
    bus.req_data  = {8'h22, 8'h11};
    tick();
    bus.stall     = 1'b1;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_ready%0d", i), 32'(bus.req_ready), 32'h0);
      check($sformatf("t5_drain%0d", i), 32'(bus.rf_regwrite), (i == 0) ? 32'h1 : 32'h0);
      tick();
    end
    bus.stall = 1'b0;
    @(negedge clk);
    check("t5_release", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();

    // 6: reset right after an accept
    bus.req_valid = 2'b01;
    bus.req_addr  = {3'd0, 3'd4};
    bus.req_data  = {8'h00, 8'h3C};
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_regwrite", 32'(bus.rf_regwrite), 32'h0);
    check("t6_pend",     32'(bus.pend),        32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_r4",        32'(rf_mem[4]),       32'h00);
    check("t6_regwrite2", 32'(bus.rf_regwrite), 32'h0);

    // Random traffic; a requester holds addr/data until granted
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      granted = bus.req_ready;
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 63) == 0);
      bus.stall = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !granted[i])) begin
          bus.req_valid[i]          = 1'($urandom_range(0, 1));
          bus.req_addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
          bus.req_data[i*DW +: DW]  = DW'($urandom_range(0, 255));
        end
      end
    end
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.req_valid = '0;
    tick();
    tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
